// File: rtl/idu_pipe_stage.sv
// Decode/issue pipeline register with operand forwarding, load-use bubbles and write-back snooping.
// Optional performance counters are enabled by defining IDU_PERF_CNT_EN.
module idu_pipe_stage #(
   parameter int XLEN     = 64,
   parameter int NUM_FWD  = 3,
   parameter int CTRL_W   = 24,
   parameter int LOAD_BIT = 20
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_instr,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [XLEN-1:0]         in_snxt_pc,
   input  logic [XLEN-1:0]         in_imm,
   input  logic [CTRL_W-1:0]       in_ctrl,
   input  logic                    in_need_rs1,
   input  logic                    in_need_rs2,
   input  logic [NUM_FWD-1:0]      fwd_en,
   input  logic [NUM_FWD*5-1:0]    fwd_rd,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_instr,
   output logic [XLEN-1:0]         out_pc,
   output logic [XLEN-1:0]         out_snxt_pc,
   output logic [XLEN-1:0]         out_imm,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [4:0]              out_rs1,
   output logic [4:0]              out_rs2,
   output logic [4:0]              out_rd,
   output logic [XLEN-1:0]         out_data_rs1,
   output logic [XLEN-1:0]         out_data_rs2,
   output logic [31:0]             perf_stall,
   output logic [31:0]             perf_bubble
);

   // x0 reads as zero; otherwise the lowest-numbered matching channel wins over dflt.
   function automatic logic [XLEN-1:0] opnd_sel(
      input logic [4:0]              idx,
      input logic [XLEN-1:0]         dflt,
      input logic [NUM_FWD-1:0]      en,
      input logic [NUM_FWD*5-1:0]    rd,
      input logic [NUM_FWD*XLEN-1:0] data
   );
      logic [XLEN-1:0] r;
      r = dflt;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (en[i] && (rd[i*5 +: 5] == idx)) r = data[i*XLEN +: XLEN];
      end
      if (idx == 5'd0) r = '0;
      return r;
   endfunction

   logic [XLEN-1:0] rf [32];

   logic [4:0]      rs1_p0, rs2_p0, rd_p0;
   logic [XLEN-1:0] opnd1_p0, opnd2_p0;
   logic [XLEN-1:0] hold1_p0, hold2_p0;
   logic            hazard, accept, hold, bubble;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   assign rs1_p0 = in_instr[19:15];
   assign rs2_p0 = in_instr[24:20];
   assign rd_p0  = in_instr[11:7];

   assign hazard = in_valid & out_valid & out_ctrl[LOAD_BIT] & (out_rd != 5'd0)
                 & ((in_need_rs1 & (rs1_p0 == out_rd)) | (in_need_rs2 & (rs2_p0 == out_rd)));
   assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
   assign accept   = in_valid & in_ready;
   assign hold     = out_valid & ~out_ready & ~flush;
   assign bubble   = ~flush & ~accept & out_ready & hazard;

   assign opnd1_p0 = opnd_sel(rs1_p0, rf[rs1_p0], fwd_en, fwd_rd, fwd_data);
   assign opnd2_p0 = opnd_sel(rs2_p0, rf[rs2_p0], fwd_en, fwd_rd, fwd_data);
   assign hold1_p0 = opnd_sel(out_rs1, out_data_rs1, fwd_en, fwd_rd, fwd_data);
   assign hold2_p0 = opnd_sel(out_rs2, out_data_rs2, fwd_en, fwd_rd, fwd_data);

   assign wb_en   = fwd_en[NUM_FWD-1];
   assign wb_rd   = fwd_rd[(NUM_FWD-1)*5 +: 5];
   assign wb_data = fwd_data[(NUM_FWD-1)*XLEN +: XLEN];

   // regfile: commit channel writes, x0 is never written
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_en && (wb_rd != 5'd0)) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // stage p1: registered issue bundle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_pc       <= '0;
         out_snxt_pc  <= '0;
         out_imm      <= '0;
         out_ctrl     <= '0;
         out_rs1      <= '0;
         out_rs2      <= '0;
         out_rd       <= '0;
         out_data_rs1 <= '0;
         out_data_rs2 <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_instr    <= in_instr;
         out_pc       <= in_pc;
         out_snxt_pc  <= in_snxt_pc;
         out_imm      <= in_imm;
         out_ctrl     <= in_ctrl;
         out_rs1      <= rs1_p0;
         out_rs2      <= rs2_p0;
         out_rd       <= rd_p0;
         out_data_rs1 <= opnd1_p0;
         out_data_rs2 <= opnd2_p0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else if (hold) begin
         out_data_rs1 <= hold1_p0;
         out_data_rs2 <= hold2_p0;
      end
   end

`ifdef IDU_PERF_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_stall  <= '0;
         perf_bubble <= '0;
      end else begin
         if (hold)   perf_stall  <= perf_stall + 32'd1;
         if (bubble) perf_bubble <= perf_bubble + 32'd1;
      end
   end
`else
   assign perf_stall  = '0;
   assign perf_bubble = '0;
`endif

endmodule

// File: tb/tb_idu_pipe_stage.sv
// Directed bench for idu_pipe_stage: reset, accept, forwarding, load-use, stall refresh, flush.
module tb_idu_pipe_stage;
   localparam int XLEN = 64, NUM_FWD = 3, CTRL_W = 24, LOAD_BIT = 20;
`ifdef IDU_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rstn, flush, in_valid, in_ready;
   logic [31:0]             in_instr;
   logic [XLEN-1:0]         in_pc, in_snxt_pc, in_imm;
   logic [CTRL_W-1:0]       in_ctrl;
   logic                    in_need_rs1, in_need_rs2;
   logic [NUM_FWD-1:0]      fwd_en;
   logic [NUM_FWD*5-1:0]    fwd_rd;
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic                    out_valid, out_ready;
   logic [31:0]             out_instr;
   logic [XLEN-1:0]         out_pc, out_snxt_pc, out_imm;
   logic [CTRL_W-1:0]       out_ctrl;
   logic [4:0]              out_rs1, out_rs2, out_rd;
   logic [XLEN-1:0]         out_data_rs1, out_data_rs2;
   logic [31:0]             perf_stall, perf_bubble;

   int checks = 0;
   int errors = 0;

   idu_pipe_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W), .LOAD_BIT(LOAD_BIT)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_snxt_pc(in_snxt_pc), .in_imm(in_imm),
      .in_ctrl(in_ctrl), .in_need_rs1(in_need_rs1), .in_need_rs2(in_need_rs2),
      .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_snxt_pc(out_snxt_pc), .out_imm(out_imm), .out_ctrl(out_ctrl),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_data_rs1(out_data_rs1), .out_data_rs2(out_data_rs2),
      .perf_stall(perf_stall), .perf_bubble(perf_bubble)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pexp(input logic [31:0] v);
      return PERF ? v : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] ins, input logic ld, input logic n1, input logic n2);
      in_valid    = 1'b1;
      in_instr    = ins;
      in_ctrl     = '0;
      in_ctrl[LOAD_BIT] = ld;
      in_need_rs1 = n1;
      in_need_rs2 = n2;
   endtask

   initial begin
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      in_snxt_pc = '0; in_imm = '0; in_ctrl = '0; in_need_rs1 = 1'b0; in_need_rs2 = 1'b0;
      fwd_en = '0; fwd_rd = '0; fwd_data = '0; out_ready = 1'b1;

      // reset
      #3;
      chk("rst_valid", out_valid, 0);
      chk("rst_rs1", out_data_rs1, 0);
      tick(); tick();
      chk("rst_stall", perf_stall, 0);
      chk("rst_bubble", perf_bubble, 0);
      rstn = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // x5 = 0x1234 through the commit channel
      fwd_en = 3'b100; fwd_rd = {5'd5, 5'd0, 5'd0}; fwd_data = {64'h1234, 64'h0, 64'h0};
      tick();
      fwd_en = '0;

      // add x7,x5,x0
      offer(32'h000283B3, 1'b0, 1'b1, 1'b1);
      in_pc = 64'h100; in_snxt_pc = 64'h104; in_imm = 64'h7;
      tick();
      in_valid = 1'b0;
      chk("acc_valid", out_valid, 1);
      chk("acc_rs1", out_data_rs1, 64'h1234);
      chk("acc_rs2", out_data_rs2, 0);
      chk("acc_rd", out_rd, 7);
      chk("acc_pc", out_pc, 64'h100);
      chk("acc_snxt", out_snxt_pc, 64'h104);
      chk("acc_imm", out_imm, 64'h7);
      tick();
      chk("drain_valid", out_valid, 0);

      // forward priority: ch0 beats ch2, x0 ignores ch1
      offer(32'h00028433, 1'b0, 1'b1, 1'b1);
      fwd_en = 3'b111; fwd_rd = {5'd5, 5'd0, 5'd5}; fwd_data = {64'hBB, 64'hFF, 64'hAA};
      tick();
      fwd_en = '0;
      chk("fwd_prio", out_data_rs1, 64'hAA);
      chk("fwd_x0", out_data_rs2, 0);
      tick();
      chk("rf_write", out_data_rs1, 64'hBB);
      in_valid = 1'b0;
      tick();

      // load-use: lw x6,0(x1) then add x9,x1,x6
      offer(32'h00008303, 1'b1, 1'b1, 1'b0);
      tick();
      chk("ld_valid", out_valid, 1);
      offer(32'h006084B3, 1'b0, 1'b1, 1'b1);
      #1;
      chk("lu_in_ready", in_ready, 0);
      tick();
      chk("lu_bubble_valid", out_valid, 0);
      chk("lu_bubble_cnt", perf_bubble, pexp(1));
      chk("lu_in_ready_after", in_ready, 1);
      fwd_en = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd6}; fwd_data = {64'h0, 64'h0, 64'h66};
      tick();
      fwd_en = '0;
      chk("lu_accept", out_valid, 1);
      chk("lu_rd", out_rd, 9);
      chk("lu_rs2", out_data_rs2, 64'h66);
      in_valid = 1'b0;
      tick();

      // stall refresh: add x10,x9,x0 held 3 cycles, ch1 writes x9 in cycle 2
      offer(32'h00048533, 1'b0, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("st_rs1_idx", out_rs1, 9);
      chk("st_rs1_init", out_data_rs1, 0);
      tick();
      chk("st_c1", out_data_rs1, 0);
      fwd_en = 3'b010; fwd_rd = {5'd0, 5'd9, 5'd0}; fwd_data = {64'h0, 64'h55, 64'h0};
      tick();
      fwd_en = '0;
      chk("st_c2", out_data_rs1, 64'h55);
      tick();
      chk("st_c3", out_data_rs1, 64'h55);
      chk("st_valid", out_valid, 1);
      chk("st_cnt", perf_stall, pexp(3));

      // flush while stalled, with a pending input
      offer(32'h000105B3, 1'b0, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      chk("fl_in_ready", in_ready, 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_rd", out_rd, 10);
      chk("fl_stall", perf_stall, pexp(3));
      tick();
      chk("fl_not_acc", out_valid, 0);

      // flush with hazard: no bubble counted
      out_ready = 1'b1;
      offer(32'h00008303, 1'b1, 1'b1, 1'b0);
      tick();
      offer(32'h006084B3, 1'b0, 1'b1, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flh_valid", out_valid, 0);
      chk("flh_bubble", perf_bubble, pexp(1));

      // reset mid-stall also clears the regfile
      out_ready = 1'b0;
      offer(32'h00028433, 1'b0, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("mr_valid", out_valid, 1);
      chk("mr_rs1", out_data_rs1, 64'hBB);
      tick();
      chk("mr_stall", perf_stall, pexp(4));
      #3;
      rstn = 1'b0;
      #1;
      chk("mr_rst_valid", out_valid, 0);
      chk("mr_rst_rs1", out_data_rs1, 0);
      chk("mr_rst_stall", perf_stall, 0);
      @(negedge clk);
      rstn = 1'b1;
      out_ready = 1'b1;
      offer(32'h00028433, 1'b0, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("mr_rf_clear", out_data_rs1, 0);
      chk("mr_acc", out_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
